// File: rtl/round_sched.sv
// Two-requester scheduler sharing one IEEE mantissa rounding stage; optional ROUND_SCHED_FIXED_PRIO_EN selects fixed priority.
// Latency 1 cycle from request transfer to out_valid; full throughput when out_ready stays high.
// Backpressure: while out_valid & !out_ready the result holds and req_ready is 2'b00.
package round_pkg;
    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } round_mode;
endpackage

module round_mult (
    input  logic [23:0]          mant,
    input  logic                 guard,
    input  logic                 sticky,
    input  logic                 sign,
    input  round_pkg::round_mode mode,
    output logic [24:0]          result,
    output logic                 inexact
);
    logic round_up;

    // Unused encodings fall back to round-to-nearest-even.
    always_comb begin
        round_up = guard & (sticky | mant[0]);
        case (mode)
            round_pkg::IEEE_zero: round_up = 1'b0;
            round_pkg::IEEE_pinf: round_up = ~sign & (guard | sticky);
            round_pkg::IEEE_ninf: round_up = sign & (guard | sticky);
            round_pkg::near_up:   round_up = guard;
            round_pkg::away_zero: round_up = guard | sticky;
            default:              round_up = guard & (sticky | mant[0]);
        endcase
    end

    assign result  = {1'b0, mant} + {24'd0, round_up};
    assign inexact = guard | sticky;
endmodule

module round_sched (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0][23:0]          req_mant,
    input  logic [1:0]                req_guard,
    input  logic [1:0]                req_sticky,
    input  logic [1:0]                req_sign,
    input  round_pkg::round_mode [1:0] req_round,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [24:0]               out_result,
    output logic                      out_inexact,
    output logic                      out_ovf,
    output logic                      out_src,
    output logic [15:0]               inexact_cnt
);
    logic        gnt;
    logic        slot_free;
    logic        xfer;
    logic [24:0] rnd_result;
    logic        rnd_inexact;

`ifdef ROUND_SCHED_FIXED_PRIO_EN
    assign gnt = ~req_valid[0];
`else
    logic rr_ptr;

    // On a tie the pointer decides; a lone requester always wins.
    assign gnt = (&req_valid) ? rr_ptr : req_valid[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (xfer) begin
            rr_ptr <= ~gnt;
        end
    end
`endif

    assign slot_free = ~out_valid | out_ready;

    always_comb begin
        req_ready = 2'b00;
        if (!rst && slot_free && req_valid[gnt]) begin
            req_ready = gnt ? 2'b10 : 2'b01;
        end
    end

    assign xfer = |(req_valid & req_ready);

    round_mult u_round_mult (
        .mant    (req_mant[gnt]),
        .guard   (req_guard[gnt]),
        .sticky  (req_sticky[gnt]),
        .sign    (req_sign[gnt]),
        .mode    (req_round[gnt]),
        .result  (rnd_result),
        .inexact (rnd_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= 25'd0;
            out_inexact <= 1'b0;
            out_src     <= 1'b0;
            inexact_cnt <= 16'd0;
        end else begin
            if (xfer) begin
                out_valid   <= 1'b1;
                out_result  <= rnd_result;
                out_inexact <= rnd_inexact;
                out_src     <= gnt;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
            if (out_valid && out_ready && out_inexact && inexact_cnt != 16'hFFFF) begin
                inexact_cnt <= inexact_cnt + 16'd1;
            end
        end
    end

    assign out_ovf = out_result[24];
endmodule
